// File: rtl/padded_stream_unpack.sv
// Strips the PAD border from a raster padded stream and assembles the interior into a parallel frame; BORDER_CHECK_EN adds sticky border_err.
// Zero added latency: valid_out rises on the edge accepting the last word; while a frame is held, words without frame_ack are dropped and flag overflow.
module padded_stream_unpack #(
    parameter int IN_W = 36,
    parameter int IN_H = 28,
    parameter int PAD  = 1,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    input  logic          frame_ack,
    output logic [DW-1:0] data_out [0:(IN_W-2*PAD)*(IN_H-2*PAD)-1],
    output logic          valid_out,
    output logic          busy,
`ifdef BORDER_CHECK_EN
    output logic          border_err,
`endif
    output logic          overflow
);

    localparam int OW = IN_W - 2*PAD;
    localparam int OH = IN_H - 2*PAD;
    localparam int NW = OW * OH;
    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);
    localparam int IW = $clog2(NW);

    localparam logic [CW-1:0] COL_LO   = CW'(PAD);
    localparam logic [CW-1:0] COL_HI   = CW'(IN_W - 1 - PAD);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LO   = RW'(PAD);
    localparam logic [RW-1:0] ROW_HI   = RW'(IN_H - 1 - PAD);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] data_q [0:NW-1];

    logic          accept;
    logic          interior;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    assign interior = (row_q >= ROW_LO) && (row_q <= ROW_HI) &&
                      (col_q >= COL_LO) && (col_q <= COL_HI);
    assign wr_idx   = IW'((int'(row_q) - PAD) * OW + int'(col_q) - PAD);
    assign wr_en    = accept && interior;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, RECV: accept = valid_in;
            HOLD: begin
                // An ack releases the buffer in the same cycle, so a coincident word starts the next frame.
                if (frame_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    accept  = valid_in;
                end else if (valid_in) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            busy_d  = 1'b1;
            state_d = RECV;
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = HOLD;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) data_q[i] <= '0;
        end else if (wr_en) begin
            data_q[wr_idx] <= data_in;
        end
    end

`ifdef BORDER_CHECK_EN
    logic berr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            berr_q <= 1'b0;
        else if (accept && !interior && (data_in != '0))
            berr_q <= 1'b1;
    end

    assign border_err = berr_q;
`endif

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_padded_stream_unpack.sv
// Self-checking bench for padded_stream_unpack: fixed vector table, directed HOLD/reset sequences, random-gap frame vs reference model.
module tb_padded_stream_unpack;

    localparam int IN_W = 36;
    localparam int IN_H = 28;
    localparam int PAD  = 1;
    localparam int DW   = 32;
    localparam int OW   = IN_W - 2*PAD;
    localparam int OH   = IN_H - 2*PAD;
    localparam int N    = OW * OH;
    localparam int FR   = IN_W * IN_H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          frame_ack;
    logic [DW-1:0] data_out [0:N-1];
    logic          valid_out;
    logic          busy;
    logic          overflow;
`ifdef BORDER_CHECK_EN
    logic          border_err;
`endif

    padded_stream_unpack #(.IN_W(IN_W), .IN_H(IN_H), .PAD(PAD), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .frame_ack (frame_ack),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
`ifdef BORDER_CHECK_EN
        .border_err(border_err),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int          errs   = 0;
    int          checks = 0;
    logic [31:0] exp_q [N];
    int          k;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } vec_t;
    vec_t tbl [6];

    // Reference: stream index k maps to (row, col); interior positions land in the frame.
    function automatic bit is_interior(input int idx);
        int r;
        int c;
        r = idx / IN_W;
        c = idx % IN_W;
        return (r >= PAD && r < IN_H - PAD && c >= PAD && c < IN_W - PAD);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) exp_q[i] = '0;
        k = 0;
    endfunction

    function automatic void model_put(input logic [31:0] v);
        if (is_interior(k))
            exp_q[(k / IN_W - PAD) * OW + (k % IN_W - PAD)] = v;
        k = (k + 1) % FR;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_frame(input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (data_out[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("note %s: first differing word %0d got 0x%0h expected 0x%0h",
                     name, first, data_out[first], exp_q[first]);
        check({name, " mismatching words"}, bad, 0);
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic a);
        valid_in  = v;
        data_in   = d;
        frame_ack = a;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send_frame(input int base, input int start, input bit gap, input string tag);
        int bb;
        int vb;
        bb = 0;
        vb = 0;
        for (int i = start; i < FR; i++) begin
            if (gap && i > 0) begin
                cyc(1'b0, 32'h0, 1'b0);
                if (busy !== 1'b1) bb++;
                if (valid_out !== 1'b0) vb++;
            end
            cyc(1'b1, base + i, 1'b0);
            model_put(base + i);
            if (i < FR - 1) begin
                if (busy !== 1'b1) bb++;
                if (valid_out !== 1'b0) vb++;
            end
        end
        check({tag, " busy-drop count"}, bb, 0);
        check({tag, " early-valid count"}, vb, 0);
        check({tag, " valid_out at last"}, valid_out, 1'b1);
        check({tag, " busy at last"}, busy, 1'b0);
    endtask

    initial begin
        tbl[0] = '{0,   32'd37};
        tbl[1] = '{33,  32'd70};
        tbl[2] = '{34,  32'd73};
        tbl[3] = '{883, 32'd970};
        tbl[4] = '{67,  32'd106};
        tbl[5] = '{850, 32'd937};

        valid_in  = 1'b0;
        data_in   = '0;
        frame_ack = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #17;
        rst_n = 1'b1;
        #1;

        check("reset valid_out", valid_out, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset overflow", overflow, 1'b0);
        cmp_frame("reset data");

        send_frame(0, 0, 1'b0, "contig");
        for (int i = 0; i < 6; i++)
            check($sformatf("contig tbl[%0d]", tbl[i].idx), data_out[tbl[i].idx], tbl[i].val);
        cmp_frame("contig frame");

        // Ack and a new word in the same cycle: release and restart with no drop.
        cyc(1'b1, 32'd1000, 1'b1);
        model_put(32'd1000);
        check("ack+word valid_out", valid_out, 1'b0);
        check("ack+word busy", busy, 1'b1);
        send_frame(1000, 1, 1'b0, "ackframe");
        check("ackframe data_out[0]", data_out[0], 32'd1037);
        check("ackframe overflow", overflow, 1'b0);
        cmp_frame("ackframe frame");

        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hAAAA_0000 + i, 1'b0);
        check("hold-drop overflow", overflow, 1'b1);
        check("hold-drop valid_out", valid_out, 1'b1);
        cmp_frame("hold-drop frame");
        cyc(1'b0, 32'h0, 1'b1);
        check("ack-alone valid_out", valid_out, 1'b0);
        check("ack-alone busy", busy, 1'b0);

        send_frame(0, 0, 1'b1, "gap");
        for (int i = 0; i < 6; i++)
            check($sformatf("gap tbl[%0d]", tbl[i].idx), data_out[tbl[i].idx], tbl[i].val);
        check("gap overflow sticky", overflow, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);

        // Random gaps, random data, stray acks outside HOLD must be ignored.
        for (int i = 0; i < FR; i++) begin
            logic [31:0] v;
            while ($urandom_range(0, 2) == 0) cyc(1'b0, $urandom, 1'($urandom_range(0, 1)));
            v = $urandom;
            cyc(1'b1, v, 1'($urandom_range(0, 1)));
            model_put(v);
        end
        check("rand valid_out", valid_out, 1'b1);
        cmp_frame("rand frame");

        do_reset();
        for (int i = 0; i < 500; i++) cyc(1'b1, i, 1'b0);
        do_reset();
        check("midreset busy", busy, 1'b0);
        check("midreset valid_out", valid_out, 1'b0);
        check("midreset overflow", overflow, 1'b0);
        cmp_frame("midreset cleared");
        send_frame(0, 0, 1'b0, "postreset");
        check("postreset data_out[0]", data_out[0], 32'd37);
        cmp_frame("postreset frame");

`ifdef BORDER_CHECK_EN
        do_reset();
        for (int i = 0; i < FR; i++) begin
            logic [31:0] v;
            v = is_interior(i) ? 32'(i + 1) : ((i == 5) ? 32'hDEAD_BEEF : 32'h0);
            cyc(1'b1, v, 1'b0);
            model_put(v);
            if (i == 4) check("berr before word 5", border_err, 1'b0);
            if (i == 5) check("berr after word 5", border_err, 1'b1);
        end
        check("berr after frame", border_err, 1'b1);
        check("berr frame valid_out", valid_out, 1'b1);
        do_reset();
        for (int i = 0; i < FR; i++) begin
            logic [31:0] v;
            v = is_interior(i) ? ($urandom | 32'h1) : 32'h0;
            cyc(1'b1, v, 1'b0);
            model_put(v);
        end
        check("berr clean frame", border_err, 1'b0);
        check("clean frame valid_out", valid_out, 1'b1);
        cmp_frame("clean frame");
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
